// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 receiver state encoding, frame geometry and shared scan-code constants.
package ps2_pkg;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;
  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  function automatic logic odd_ok(input logic [DATA_BITS:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/ps2_scancode_rx_if.sv
// ps2_scancode_rx_if: scan-code history and status from the PS/2 receiver to the keyboard controller.
interface ps2_scancode_rx_if;
  logic [15:0] KBBuffer;
  logic        Rx_Valid;
  logic        Frame_Error;
  logic        Busy;
  modport master (output KBBuffer, Rx_Valid, Frame_Error, Busy);
  modport slave  (input KBBuffer, Rx_Valid, Frame_Error, Busy);
endinterface

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: synchronises the PS/2 pins, debounces PS2_CLK and strobes on its filtered falling edge.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic PS2_CLK,
  input  logic PS2_DATA,
  output logic strobe,
  output logic data
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0] cs_q, cs_d, ds_q, ds_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic filt_q, filt_d, stb_q, stb_d, flip;
  // the filtered level only moves after FILTER_LEN consecutive disagreeing samples
  always_comb begin
    cs_d = {cs_q[0], PS2_CLK};
    ds_d = {ds_q[0], PS2_DATA};
    flip = (cs_q[1] != filt_q) && (cnt_q == CW'(FILTER_LEN - 1));
    cnt_d = (cs_q[1] == filt_q || flip) ? '0 : cnt_q + 1'b1;
    filt_d = flip ? cs_q[1] : filt_q;
    stb_d = flip && !cs_q[1];
  end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      cs_q <= 2'b11;
      ds_q <= 2'b11;
      cnt_q <= '0;
      filt_q <= 1'b1;
      stb_q <= 1'b0;
    end else begin
      cs_q <= cs_d;
      ds_q <= ds_d;
      cnt_q <= cnt_d;
      filt_q <= filt_d;
      stb_q <= stb_d;
    end
  assign strobe = stb_q;
  assign data = ds_q[1];
endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 keyboard deframer keeping the {previous, newest} scan-code history word.
// Define PS2_PARITY_CHECK_EN to reject frames whose D0..D7+parity do not have odd weight.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TO_W           = 17
) (
  input logic CLK,
  input logic RESET_N,
  input logic PS2_CLK,
  input logic PS2_DATA,
  ps2_scancode_rx_if.master rx
);
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  logic stb, dat, par_ok, timeout;
  logic [1:0] state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic par_q, par_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [15:0] kb_q, kb_d;
  logic rxv_q, rxv_d, ferr_q, ferr_d;
  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .CLK(CLK), .RESET_N(RESET_N), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .strobe(stb), .data(dat)
  );
  assign par_ok = !PAR_EN || odd_ok({par_q, sh_q});
  assign timeout = (state_q != IDLE) && (to_q == TO_W'(TIMEOUT_CYCLES - 1));
  // a strobe always beats a simultaneous timeout
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    sh_d = sh_q;
    par_d = par_q;
    kb_d = kb_q;
    rxv_d = 1'b0;
    ferr_d = 1'b0;
    to_d = (stb || state_q == IDLE) ? '0 : to_q + 1'b1;
    if (stb) begin
      case (state_q)
        IDLE: begin
          state_d = dat ? IDLE : DATA;
          bit_d = '0;
        end
        DATA: begin
          sh_d = {dat, sh_q[DATA_BITS-1:1]};
          bit_d = bit_q + 1'b1;
          state_d = (bit_q == 3'(DATA_BITS - 1)) ? PARITY : DATA;
        end
        PARITY: begin
          par_d = dat;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          rxv_d = dat && par_ok;
          ferr_d = !(dat && par_ok);
          kb_d = (dat && par_ok) ? {kb_q[7:0], sh_q} : kb_q;
        end
      endcase
    end else if (timeout) begin
      state_d = IDLE;
      ferr_d = 1'b1;
    end
  end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state_q <= IDLE;
      bit_q <= '0;
      sh_q <= '0;
      par_q <= 1'b0;
      to_q <= '0;
      kb_q <= '0;
      rxv_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      par_q <= par_d;
      to_q <= to_d;
      kb_q <= kb_d;
      rxv_q <= rxv_d;
      ferr_q <= ferr_d;
    end
  assign rx.KBBuffer = kb_q;
  assign rx.Rx_Valid = rxv_q;
  assign rx.Frame_Error = ferr_q;
  assign rx.Busy = state_q != IDLE;
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: randomized and directed PS/2 frames checked against a frame-level outcome model.
module tb_ps2_scancode_rx;
  localparam int HALF = 20;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  typedef struct {
    bit err;
    logic [7:0] b;
  } ev_t;
  logic clk = 1'b0, rst_n = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  int checks = 0, failures = 0, rv_cnt = 0, fe_cnt = 0;
  logic [15:0] model_kb = '0;
  logic busy_mid = 1'b0;
  ev_t exp_q[$];

  ps2_scancode_rx_if rx_if ();
  ps2_scancode_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(64), .TO_W(7)) dut (
    .CLK(clk), .RESET_N(rst_n), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data), .rx(rx_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // each frame's fate is predicted when sent; DUT pulses consume predictions in order
  always @(negedge clk) begin : cmp
    ev_t e;
    if (!rst_n) begin
      chk("reset_outputs", {13'b0, rx_if.KBBuffer, rx_if.Rx_Valid, rx_if.Frame_Error, rx_if.Busy}, 0);
      model_kb = '0;
    end else begin
      if (rx_if.Rx_Valid || rx_if.Frame_Error) begin
        chk("pulse_exclusive", {31'b0, rx_if.Rx_Valid & rx_if.Frame_Error}, 0);
        if (exp_q.size() == 0) chk("unexpected_pulse", {30'b0, rx_if.Rx_Valid, rx_if.Frame_Error}, 0);
        else begin
          e = exp_q.pop_front();
          chk("pulse_kind", {30'b0, rx_if.Rx_Valid, rx_if.Frame_Error}, e.err ? 32'd1 : 32'd2);
          if (!e.err) model_kb = {model_kb[7:0], e.b};
        end
        rv_cnt += int'(rx_if.Rx_Valid);
        fe_cnt += int'(rx_if.Frame_Error);
      end
      chk("kbbuffer", {16'b0, rx_if.KBBuffer}, {16'b0, model_kb});
    end
  end

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  // nbits < 11 stops clocking mid-frame, so a timeout error is the predicted outcome
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop, input int nbits);
    logic [10:0] f;
    ev_t e;
    f = {stop, ~(^d) ^ bad_par, d, 1'b0};
    e.err = (nbits < 11) || !stop || (PAR_EN && bad_par);
    e.b = d;
    exp_q.push_back(e);
    for (int i = 0; i < nbits; i++) begin
      ps2_bit(f[i]);
      if (i == 5) begin
        @(negedge clk);
        busy_mid = rx_if.Busy;
      end
    end
  endtask

  initial begin
    int r0, f0;
    logic [15:0] lit;
    logic [7:0] d;
    int sel;
    #2 rst_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset_kb", {16'b0, rx_if.KBBuffer}, 0);
    chk("reset_flags", {29'b0, rx_if.Rx_Valid, rx_if.Frame_Error, rx_if.Busy}, 0);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    r0 = rv_cnt; f0 = fe_cnt;
    send_frame(8'h1C, 0, 1, 11);
    @(negedge clk);
    chk("first_kb", {16'b0, rx_if.KBBuffer}, 32'h001C);
    chk("first_rv_count", rv_cnt - r0, 1);
    chk("first_fe_count", fe_cnt - f0, 0);
    chk("first_busy_mid", {31'b0, busy_mid}, 1);
    chk("first_busy_end", {31'b0, rx_if.Busy}, 0);
    send_frame(8'hF0, 0, 1, 11);
    @(negedge clk);
    chk("break_kb", {16'b0, rx_if.KBBuffer}, 32'h1CF0);
    send_frame(8'h1C, 0, 1, 11);
    @(negedge clk);
    chk("release_kb", {16'b0, rx_if.KBBuffer}, 32'hF01C);
    chk("three_rv", rv_cnt - r0, 3);
    f0 = fe_cnt;
    send_frame(8'h1C, 1, 1, 11);
    @(negedge clk);
    lit = PAR_EN ? 16'hF01C : 16'h1C1C;
    chk("even_parity_kb", {16'b0, rx_if.KBBuffer}, {16'b0, lit});
    chk("even_parity_fe", fe_cnt - f0, PAR_EN ? 1 : 0);
    f0 = fe_cnt;
    send_frame(8'h33, 0, 0, 11);
    @(negedge clk);
    chk("bad_stop_kb", {16'b0, rx_if.KBBuffer}, {16'b0, lit});
    chk("bad_stop_fe", fe_cnt - f0, 1);
    send_frame(8'h5A, 0, 1, 11);
    @(negedge clk);
    chk("after_err_kb", {16'b0, rx_if.KBBuffer}, {16'b0, lit[7:0], 8'h5A});
    f0 = fe_cnt;
    send_frame(8'hA5, 0, 1, 5);
    @(negedge clk);
    chk("timeout_busy_before", {31'b0, rx_if.Busy}, 1);
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("timeout_busy_after", {31'b0, rx_if.Busy}, 0);
    chk("timeout_fe", fe_cnt - f0, 1);
    send_frame(8'h76, 0, 1, 11);
    @(negedge clk);
    chk("after_timeout_kb", {16'b0, rx_if.KBBuffer}, 32'h5A76);
    r0 = rv_cnt; f0 = fe_cnt;
    @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy", {31'b0, rx_if.Busy}, 0);
    chk("glitch_pulses", (rv_cnt - r0) + (fe_cnt - f0), 0);
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      sel = int'($urandom_range(0, 9));
      send_frame(d, sel == 0, sel != 1, 11);
      repeat (int'($urandom_range(0, 15))) @(posedge clk);
    end
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midframe_reset", {13'b0, rx_if.KBBuffer, rx_if.Rx_Valid, rx_if.Frame_Error, rx_if.Busy}, 0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    send_frame(8'h29, 0, 1, 11);
    @(negedge clk);
    chk("post_reset_kb", {16'b0, rx_if.KBBuffer}, 32'h0029);
    repeat (10) @(posedge clk);
    chk("all_events_seen", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
